apb_intf: RTL and testbench
===========================

Name: apb_intf

Overview:
- APB4 requester (master) bridge: accepts single read/write commands on a simple valid/ready command port, drives one APB transfer per command and returns a one-cycle response.
- Sits between on-chip control logic and the APB fabric.
- Drives a one-hot PSEL for NUM_SLV completers (slave 0 = LEDs/RGB/switch/button block, slave 1 = second peripheral). PREADY/PRDATA/PSLVERR arrive already muxed by the fabric.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- NUM_SLV, 2, number of completers (one-hot PSEL width).
- SLV_SIZE_LOG2, 12, each completer window is 2^12 bytes.
- TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY before abort.

Ports:
- pclk  in  1  APB clock; all logic on its rising edge.
- prstn  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_addr  in  AW  byte address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_wdata  in  DW  write data.
- cmd_strb  in  DW/8  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DW  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR, decode error or timeout.
- paddr  out  AW  APB address.
- psel  out  NUM_SLV  one-hot select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DW  APB write data.
- pstrb  out  DW/8  APB strobes.
- pprot  out  3  tied to 3'b000.
- pready  in  1  muxed completer ready.
- prdata  in  DW  muxed read data.
- pslverr  in  1  muxed completer error.

Behaviour:
- Reset (prstn=0, asynchronous): state IDLE. All outputs 0 except cmd_ready=1. A transfer in flight is aborted with no response.
- FSM states:
  - IDLE: cmd_ready=1.
  - SETUP: psel one-hot, penable=0.
  - ACCESS: psel held, penable=1.
- IDLE→SETUP on cmd_valid & cmd_ready, if the address decodes. Command fields are registered at the accept edge. cmd_ready=0 outside IDLE.
- Decode: index = cmd_addr[SLV_SIZE_LOG2 +: clog2(NUM_SLV)]. Valid only if all bits above that field are 0 and index < NUM_SLV.
- Decode error: no APB activity. The next cycle has rsp_valid=1, rsp_err=1, rsp_rdata=0, and the FSM returns to IDLE.
- SETUP→ACCESS unconditionally after 1 cycle.
- paddr/pwrite/pwdata/pstrb/psel are stable from SETUP through the last ACCESS cycle.
- pstrb=0 on reads. pwdata holds the registered value on reads (don't-care to completers).
- ACCESS: transfer completes when pready=1 is sampled.
  - Next cycle: rsp_valid=1; rsp_err=pslverr; rsp_rdata=prdata for a read without error, else 0.
  - psel=0, penable=0, FSM back in IDLE with cmd_ready=1.
- pslverr and prdata are ignored while pready=0.
- Timeout: if pready is still 0 after TIMEOUT ACCESS cycles, drop psel/penable, then respond with rsp_err=1, rsp_rdata=0.
- Latency, accept edge at cycle k:
  - SETUP k+1, ACCESS k+2.
  - With pready=1 at k+2: rsp_valid at k+3, next accept at k+3. This gives 3 cycles per zero-wait transfer.
- Each extra wait state adds 1 cycle.
- paddr, pwrite, pwdata and pstrb retain their last values in IDLE; psel and penable are 0.
- rsp_* fields hold until the next response; only rsp_valid pulses.
- No back-to-back SETUP without returning through IDLE.

Decomposition:
- Package apb_pkg:
  - state enum (IDLE, SETUP, ACCESS, RESP_ERR);
  - localparams for default AW/DW;
  - pprot constant 3'b000.
- One sub-module, apb_addr_decode: combinational cmd_addr→{one-hot psel, decode_err}. Everything else lives in apb_intf.

Test Plan:
- Reset: prstn=0 mid-ACCESS → psel=0, penable=0, rsp_valid stays 0, cmd_ready=1 immediately.
- Zero-wait write, addr 0x0000_0010, wdata 0xFFFF_FFFF, strb 0xF:
  - SETUP: psel=01, penable=0; ACCESS: penable=1, pstrb=F.
  - rsp_valid at k+3, rsp_err=0, rsp_rdata=0.
- Read of addr 0x0000_1004 with 2 wait states, prdata=0xA5A5_0001 → psel=10, penable high for 3 cycles, rsp_rdata=0xA5A5_0001, rsp_valid at k+5.
- Read with pslverr=1 on completion → rsp_err=1, rsp_rdata=0.
- Decode error, addr 0x0000_2000 → no psel ever asserted, rsp_valid at k+1 with rsp_err=1.
- Timeout: pready held 0 → psel/penable drop after 16 ACCESS cycles, rsp_err=1. A back-to-back command is accepted the following cycle.

Source files
------------

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the APB4 requester bridge.
//   apb_state_e   : bridge state machine encoding
//   DEF_AW/DEF_DW : default address/data widths
//   PPROT_DEFAULT : protection attribute driven on every transfer
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Normal, secure, data access on every transfer
    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

    // RESP_ERR is the one-cycle response slot after a command that
    // decodes to no completer; the APB bus stays idle throughout
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP_ERR
    } apb_state_e;

endpackage

// File: rtl/apb_addr_decode.sv
// ---------------------------------------------------------------------------
// apb_addr_decode
// Combinational address decoder for the APB bridge. Each completer owns a
// 2^SLV_SIZE_LOG2-byte window starting at address 0.
//   addr       in  AW       byte address of the command
//   sel        out NUM_SLV  one-hot completer select (all zero on error)
//   decode_err out 1        address hits no completer
// ---------------------------------------------------------------------------
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int AW            = DEF_AW,
    parameter int NUM_SLV       = 2,
    parameter int SLV_SIZE_LOG2 = 12
) (
    input  logic [AW-1:0]      addr,
    output logic [NUM_SLV-1:0] sel,
    output logic               decode_err
);

    localparam int IDX_BITS = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 0;

    logic [AW-1:0] window;
    logic [AW-1:0] index;
    logic [AW-1:0] upper;

    // The window number is split into the completer index field and the
    // bits above it; any set bit above the field is outside the fabric,
    // and an index past the last completer is a hole in the map.
    always_comb begin
        window     = addr >> SLV_SIZE_LOG2;
        index      = window & ((AW'(1) << IDX_BITS) - AW'(1));
        upper      = window >> IDX_BITS;
        decode_err = (upper != '0) || (index >= AW'(NUM_SLV));
        sel        = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!decode_err && (index == AW'(i))) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_intf.sv
// ---------------------------------------------------------------------------
// apb_intf
// APB4 requester bridge: takes single read/write commands on a valid/ready
// port, runs one APB transfer per command and returns a one-cycle response.
//   pclk, prstn             clock / async active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_addr/cmd_write/cmd_wdata/cmd_strb  command fields
//   rsp_valid/rsp_rdata/rsp_err            response (valid pulses, rest held)
//   paddr/psel/penable/pwrite/pwdata/pstrb/pprot  APB requester outputs
//   pready/prdata/pslverr   muxed completer inputs
// ---------------------------------------------------------------------------
module apb_intf
    import apb_pkg::*;
#(
    parameter int AW            = DEF_AW,
    parameter int DW            = DEF_DW,
    parameter int NUM_SLV       = 2,
    parameter int SLV_SIZE_LOG2 = 12,
    parameter int TIMEOUT       = 16
) (
    input  logic                pclk,
    input  logic                prstn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [AW-1:0]       cmd_addr,
    input  logic                cmd_write,
    input  logic [DW-1:0]       cmd_wdata,
    input  logic [DW/8-1:0]     cmd_strb,

    output logic                rsp_valid,
    output logic [DW-1:0]       rsp_rdata,
    output logic                rsp_err,

    output logic [AW-1:0]       paddr,
    output logic [NUM_SLV-1:0]  psel,
    output logic                penable,
    output logic                pwrite,
    output logic [DW-1:0]       pwdata,
    output logic [DW/8-1:0]     pstrb,
    output logic [2:0]          pprot,
    input  logic                pready,
    input  logic [DW-1:0]       prdata,
    input  logic                pslverr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e state, next_state;

    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_err;
    logic [NUM_SLV-1:0] psel_q;
    logic [CNT_W-1:0]   wait_cnt;

    logic accept;
    logic complete;
    logic abort;

    apb_addr_decode #(
        .AW            (AW),
        .NUM_SLV       (NUM_SLV),
        .SLV_SIZE_LOG2 (SLV_SIZE_LOG2)
    ) u_decode (
        .addr       (cmd_addr),
        .sel        (dec_sel),
        .decode_err (dec_err)
    );

    // State register; reset drops any transfer in flight without a response
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. wait_cnt counts ACCESS cycles already spent with
    // pready low, so the abort fires at the end of the TIMEOUT-th one.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    next_state = dec_err ? RESP_ERR : SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            RESP_ERR: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign penable   = (state == ACCESS);
    assign psel      = ((state == SETUP) || (state == ACCESS)) ? psel_q : '0;
    assign pprot     = PPROT_DEFAULT;

    // Command capture, wait counter and response registers. APB fields are
    // only loaded for commands that decode, so a rejected command leaves the
    // bus exactly as the last real transfer left it.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            psel_q    <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;

            if (accept && !dec_err) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
                pstrb  <= cmd_write ? cmd_strb : '0;
                psel_q <= dec_sel;
            end

            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if ((state == ACCESS) && !pready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (accept && dec_err) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end

            if (complete) begin
                rsp_valid <= 1'b1;
                rsp_err   <= pslverr;
                rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
            end

            if (abort) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_intf.sv
// ---------------------------------------------------------------------------
// tb_apb_intf
// Directed testbench for the apb_intf APB4 requester bridge. The bench plays
// the role of the muxed completer by driving pready/prdata/pslverr directly.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_apb_intf;

    logic        pclk;
    logic        prstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic [1:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int vec_cnt = 0;
    int err_cnt = 0;

    apb_intf dut (
        .pclk      (pclk),
        .prstn     (prstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pprot     (pprot),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Presents one command at the current falling edge, lets it be taken on
    // the next rising edge and returns at the following falling edge, i.e.
    // in the SETUP cycle of a decoded command
    task automatic issue(input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_valid = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
    endtask

    // Power-on values, then an asynchronous reset in the middle of ACCESS
    task automatic test_reset();
        @(negedge pclk);
        vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL por_cmd_ready got %b want 1", cmd_ready); end
        vec_cnt++; if ({psel, penable, rsp_valid, rsp_err} !== 5'b0) begin err_cnt++; $display("FAIL por_ctrl got %b want 00000", {psel, penable, rsp_valid, rsp_err}); end
        vec_cnt++; if ({paddr, pwdata, pstrb, pwrite, rsp_rdata, pprot} !== '0) begin err_cnt++; $display("FAIL por_data got %h want 0", {paddr, pwdata, pstrb, pwrite, rsp_rdata, pprot}); end
        prstn = 1'b1;
        @(negedge pclk);
        pready = 1'b0;
        issue(32'h0000_0000, 1'b0, 32'h0, 4'h0);
        @(negedge pclk);
        vec_cnt++; if (penable !== 1'b1) begin err_cnt++; $display("FAIL rst_pre_access got %b want 1", penable); end
        #2 prstn = 1'b0;
        #1;
        vec_cnt++; if ({psel, penable} !== 3'b000) begin err_cnt++; $display("FAIL rst_async_bus got %b want 000", {psel, penable}); end
        vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_async_ready got %b want 1", cmd_ready); end
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_no_rsp got %b want 0", rsp_valid); end
        end
        prstn = 1'b1;
        @(negedge pclk);
    endtask

    // Zero-wait write to completer 0
    task automatic test_write();
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 32'h1111_2222;
        vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL wr_ready got %b want 1", cmd_ready); end
        issue(32'h0000_0010, 1'b1, 32'hFFFF_FFFF, 4'hF);
        vec_cnt++; if ({psel, penable, cmd_ready} !== 4'b0100) begin err_cnt++; $display("FAIL wr_setup got %b want 0100", {psel, penable, cmd_ready}); end
        vec_cnt++; if ({paddr, pwrite} !== {32'h0000_0010, 1'b1}) begin err_cnt++; $display("FAIL wr_addr got %h want 000000101", {paddr, pwrite}); end
        @(negedge pclk);
        vec_cnt++; if ({psel, penable, pstrb} !== 7'b01_1_1111) begin err_cnt++; $display("FAIL wr_access got %b want 0111111", {psel, penable, pstrb}); end
        vec_cnt++; if ((pwdata !== 32'hFFFF_FFFF) || (rsp_valid !== 1'b0)) begin err_cnt++; $display("FAIL wr_wdata got %h/%b want ffffffff/0", pwdata, rsp_valid); end
        @(negedge pclk);
        vec_cnt++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin err_cnt++; $display("FAIL wr_rsp got %b %b %h want 1 0 00000000", rsp_valid, rsp_err, rsp_rdata); end
        vec_cnt++; if ({psel, penable, cmd_ready} !== 4'b0001) begin err_cnt++; $display("FAIL wr_idle got %b want 0001", {psel, penable, cmd_ready}); end
        @(negedge pclk);
        vec_cnt++; if ({rsp_valid, paddr} !== {1'b0, 32'h0000_0010}) begin err_cnt++; $display("FAIL wr_hold got %h want 000000010", {rsp_valid, paddr}); end
    endtask

    // Read from completer 1 with two wait states; stale pslverr/prdata
    // while pready is low must be ignored
    task automatic test_read_wait();
        int en_cycles;
        en_cycles = 0;
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = 32'hDEAD_DEAD;
        issue(32'h0000_1004, 1'b0, 32'h0BAD_F00D, 4'hF);
        vec_cnt++; if ({psel, penable, pstrb} !== 7'b10_0_0000) begin err_cnt++; $display("FAIL rd_setup got %b want 1000000", {psel, penable, pstrb}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            if (penable === 1'b1) en_cycles++;
            vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rd_wait_rsp cycle %0d got %b want 0", i, rsp_valid); end
        end
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 32'hA5A5_0001;
        @(negedge pclk);
        vec_cnt++; if (en_cycles !== 3) begin err_cnt++; $display("FAIL rd_penable_cycles got %0d want 3", en_cycles); end
        vec_cnt++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hA5A5_0001}) begin err_cnt++; $display("FAIL rd_rsp got %b %b %h want 1 0 a5a50001", rsp_valid, rsp_err, rsp_rdata); end
        vec_cnt++; if (psel !== 2'b00) begin err_cnt++; $display("FAIL rd_psel_drop got %b want 00", psel); end
        @(negedge pclk);
    endtask

    // Completer error on a zero-wait read
    task automatic test_slverr();
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h0000_1234;
        issue(32'h0000_0008, 1'b0, 32'h0, 4'h0);
        @(negedge pclk);
        vec_cnt++; if (penable !== 1'b1) begin err_cnt++; $display("FAIL err_access got %b want 1", penable); end
        @(negedge pclk);
        vec_cnt++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin err_cnt++; $display("FAIL err_rsp got %b %b %h want 1 1 00000000", rsp_valid, rsp_err, rsp_rdata); end
        pslverr = 1'b0;
        @(negedge pclk);
    endtask

    // Address outside every completer window
    task automatic test_decode_err();
        logic seen_sel;
        seen_sel = 1'b0;
        pready   = 1'b1;
        issue(32'h0000_2000, 1'b1, 32'h5555_5555, 4'hF);
        if (psel !== 2'b00) seen_sel = 1'b1;
        vec_cnt++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin err_cnt++; $display("FAIL dec_rsp got %b %b %h want 1 1 00000000", rsp_valid, rsp_err, rsp_rdata); end
        vec_cnt++; if (penable !== 1'b0) begin err_cnt++; $display("FAIL dec_penable got %b want 0", penable); end
        @(negedge pclk);
        if (psel !== 2'b00) seen_sel = 1'b1;
        vec_cnt++; if ({cmd_ready, rsp_valid, rsp_err} !== 3'b101) begin err_cnt++; $display("FAIL dec_idle got %b want 101", {cmd_ready, rsp_valid, rsp_err}); end
        vec_cnt++; if ({paddr, pwdata} !== {32'h0000_0008, 32'h0}) begin err_cnt++; $display("FAIL dec_bus_kept got %h want 0000000800000000", {paddr, pwdata}); end
        @(negedge pclk);
        if (psel !== 2'b00) seen_sel = 1'b1;
        vec_cnt++; if (seen_sel !== 1'b0) begin err_cnt++; $display("FAIL dec_psel got %b want 0", seen_sel); end
    endtask

    // Completer never answers; followed by a command in the response cycle
    task automatic test_timeout();
        int en_cycles;
        en_cycles = 0;
        pready  = 1'b0;
        issue(32'h0000_1000, 1'b1, 32'h1234_5678, 4'h3);
        for (int i = 0; i < 16; i++) begin
            @(negedge pclk);
            if (penable === 1'b1) en_cycles++;
            vec_cnt++; if ({psel, rsp_valid} !== 3'b100) begin err_cnt++; $display("FAIL to_wait cycle %0d got %b want 100", i, {psel, rsp_valid}); end
        end
        @(negedge pclk);
        vec_cnt++; if (en_cycles !== 16) begin err_cnt++; $display("FAIL to_access_cycles got %0d want 16", en_cycles); end
        vec_cnt++; if ({psel, penable, cmd_ready} !== 4'b0001) begin err_cnt++; $display("FAIL to_drop got %b want 0001", {psel, penable, cmd_ready}); end
        vec_cnt++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin err_cnt++; $display("FAIL to_rsp got %b %b %h want 1 1 00000000", rsp_valid, rsp_err, rsp_rdata); end
        pready = 1'b1;
        prdata = 32'h0000_BEEF;
        issue(32'h0000_0000, 1'b0, 32'h0, 4'hF);
        vec_cnt++; if ({psel, penable, pstrb, pwrite} !== 8'b01_0_0000_0) begin err_cnt++; $display("FAIL b2b_setup got %b want 01000000", {psel, penable, pstrb, pwrite}); end
        @(negedge pclk);
        @(negedge pclk);
        vec_cnt++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0000_BEEF}) begin err_cnt++; $display("FAIL b2b_rsp got %b %b %h want 1 0 0000beef", rsp_valid, rsp_err, rsp_rdata); end
    endtask

    initial begin
        prstn     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_decode_err();
        test_timeout();
        @(negedge pclk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Backstop so a stuck run still ends with a report
    initial begin
        #20000;
        err_cnt++;
        $display("FAIL watchdog got timeout want finish");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
